// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos iteration controller: default data width,
// FSM state encoding and float64 bit patterns used by benches.
package chaos_pkg;

    localparam int DATA_WIDTH_DEF = 64;

    // Controller states, exposed on the debug port of chaos_iter_ctrl.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [63:0] FP_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] FP_ZERO = 64'h0000000000000000;

endpackage

// File: rtl/chaos_result_latch.sv
// Per-axis result capture: holds the first value strobed in while armed and
// flags it; reports repeated strobes (dup) and strobes outside WAIT (stray).
module chaos_result_latch #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture_i,
    input  logic         clear_i,
    input  logic         armed_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] data_o,
    output logic         flag_o,
    output logic         dup_err_o,
    output logic         stray_err_o
);

    logic [W-1:0] data_q, data_d;
    logic         flag_q, flag_d;

    // First strobe while armed wins; later strobes never overwrite it.
    always_comb begin
        data_d = data_q;
        flag_d = flag_q;
        if (clear_i) begin
            flag_d = 1'b0;
        end else if (armed_i && capture_i && !flag_q) begin
            data_d = din_i;
            flag_d = 1'b1;
        end
    end

    // Capture register and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            flag_q <= 1'b0;
        end else begin
            data_q <= data_d;
            flag_q <= flag_d;
        end
    end

    assign data_o      = data_q;
    assign flag_o      = flag_q;
    assign dup_err_o   = armed_i & capture_i & flag_q;
    assign stray_err_o = capture_i & ~armed_i;

endmodule

// File: rtl/chaos_iter_ctrl.sv
// Iteration controller in front of the per-axis forward-Euler stages.
// Issues (xn, yn, zn), gathers xn1/yn1/zn1 in any order, feeds them back and
// streams each completed state vector. Data is treated as opaque bits.
// Optional macro CHAOS_ITER_WDOG_EN adds a WAIT watchdog of WDOG_CYCLES.
//
// Handshake: the controller's *_valid outputs and the stages' *1_valid
// strobes are single-cycle pulses with no backpressure; data is meaningful
// only in the cycle its valid is high.
module chaos_iter_ctrl
    import chaos_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ITER_W      = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] z0,
    input  logic [ITER_W-1:0]     iter_num,
    output logic                  xn_valid,
    output logic                  yn_valid,
    output logic                  zn_valid,
    output logic [DATA_WIDTH-1:0] xn,
    output logic [DATA_WIDTH-1:0] yn,
    output logic [DATA_WIDTH-1:0] zn,
    input  logic                  xn1_valid,
    input  logic                  yn1_valid,
    input  logic                  zn1_valid,
    input  logic [DATA_WIDTH-1:0] xn1,
    input  logic [DATA_WIDTH-1:0] yn1,
    input  logic [DATA_WIDTH-1:0] zn1,
    output logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] sample_x,
    output logic [DATA_WIDTH-1:0] sample_y,
    output logic [DATA_WIDTH-1:0] sample_z,
    output logic [ITER_W-1:0]     iter_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output state_e                dbg_state
);

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] x_q, y_q, z_q;
    logic [ITER_W-1:0]     iter_num_q, iter_cnt_q, iter_cnt_inc;
    logic                  sample_valid_q, err_q, err_d;

    logic [DATA_WIDTH-1:0] x_cap, y_cap, z_cap, x_eff, y_eff, z_eff;
    logic                  x_flag, y_flag, z_flag;
    logic                  x_dup, y_dup, z_dup, x_stray, y_stray, z_stray;
    logic                  armed, clear_flags, start_acc, complete, wdog_to;

    assign armed        = (state_q == WAIT);
    assign clear_flags  = (state_q == ISSUE);
    assign start_acc    = (state_q == IDLE) && start;
    assign iter_cnt_inc = iter_cnt_q + 1'b1;

    chaos_result_latch #(.W(DATA_WIDTH)) u_lat_x (
        .clk(clk), .rst_n(rst_n), .capture_i(xn1_valid), .clear_i(clear_flags),
        .armed_i(armed), .din_i(xn1), .data_o(x_cap), .flag_o(x_flag),
        .dup_err_o(x_dup), .stray_err_o(x_stray)
    );
    chaos_result_latch #(.W(DATA_WIDTH)) u_lat_y (
        .clk(clk), .rst_n(rst_n), .capture_i(yn1_valid), .clear_i(clear_flags),
        .armed_i(armed), .din_i(yn1), .data_o(y_cap), .flag_o(y_flag),
        .dup_err_o(y_dup), .stray_err_o(y_stray)
    );
    chaos_result_latch #(.W(DATA_WIDTH)) u_lat_z (
        .clk(clk), .rst_n(rst_n), .capture_i(zn1_valid), .clear_i(clear_flags),
        .armed_i(armed), .din_i(zn1), .data_o(z_cap), .flag_o(z_flag),
        .dup_err_o(z_dup), .stray_err_o(z_stray)
    );

    // A strobe arriving this cycle counts immediately, so the last result at
    // cycle T produces the next issue at T+1.
    assign x_eff    = x_flag ? x_cap : xn1;
    assign y_eff    = y_flag ? y_cap : yn1;
    assign z_eff    = z_flag ? z_cap : zn1;
    assign complete = armed && (x_flag || xn1_valid) && (y_flag || yn1_valid)
                            && (z_flag || zn1_valid);

`ifdef CHAOS_ITER_WDOG_EN
    localparam int WdogW = $clog2(WDOG_CYCLES + 1);
    logic [WdogW-1:0] wdog_q, wdog_d;

    // Count cycles spent in WAIT; restart on every issue.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ISSUE) begin
            wdog_d = '0;
        end else if (state_q == WAIT) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_to = armed && !complete && (wdog_q == WdogW'(WDOG_CYCLES - 1));
`else
    assign wdog_to = 1'b0;
    // WDOG_CYCLES only matters when the watchdog is built in.
    if (WDOG_CYCLES < 1) begin : g_wdog_cfg_unused
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (iter_num == '0) ? DONE : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (complete) begin
                    state_d = (iter_cnt_inc == iter_num_q) ? DONE : ISSUE;
                end else if (wdog_to) begin
                    state_d = DONE;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        xn_valid = (state_q == ISSUE);
        yn_valid = (state_q == ISSUE);
        zn_valid = (state_q == ISSUE);
        busy     = (state_q == ISSUE) || (state_q == WAIT);
        done     = (state_q == DONE);
    end

    // Sticky error: start clears it, any stray/duplicate strobe or timeout sets it.
    always_comb begin
        err_d = start_acc ? 1'b0 : err_q;
        if (x_dup || y_dup || z_dup || x_stray || y_stray || z_stray || wdog_to) begin
            err_d = 1'b1;
        end
    end

    // State vector, iteration bookkeeping, sample pulse and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
            iter_num_q     <= '0;
            iter_cnt_q     <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (start_acc) begin
                x_q        <= x0;
                y_q        <= y0;
                z_q        <= z0;
                iter_num_q <= iter_num;
                iter_cnt_q <= '0;
            end else if (complete) begin
                x_q        <= x_eff;
                y_q        <= y_eff;
                z_q        <= z_eff;
                iter_cnt_q <= iter_cnt_inc;
            end
            sample_valid_q <= complete;
            err_q          <= err_d;
        end
    end

    // The state registers double as the issue bus and the sample bus.
    assign xn           = x_q;
    assign yn           = y_q;
    assign zn           = z_q;
    assign sample_x     = x_q;
    assign sample_y     = y_q;
    assign sample_z     = z_q;
    assign sample_valid = sample_valid_q;
    assign iter_cnt     = iter_cnt_q;
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule
